// File: rtl/switch_bounce_gen.sv
// Contact-bounce emulator: turns each clean level change into a toggle burst, a settle window, then the steady level.
// Optional macro BOUNCE_RANDOM_EN gates the burst toggles with an 8-bit LFSR.
module switch_bounce_gen #(
  parameter int       TICK_DIV     = 4,
  parameter int       BOUNCE_LEN   = 4,
  parameter int       STABLE_TICKS = 2,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       sw_clean,
  output logic       sw_bouncy,
  output logic       busy,
  output logic       done,
  output logic [7:0] toggle_cnt
);

  localparam int PW       = $clog2(TICK_DIV);
  localparam int SLOT_MAX = (BOUNCE_LEN > STABLE_TICKS) ? BOUNCE_LEN : STABLE_TICKS;
  localparam int SW       = $clog2(SLOT_MAX + 1);

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] BOUNCE_LAST = SW'(BOUNCE_LEN);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS);
  localparam logic [SW-1:0] SLOT_ONE    = SW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic            target_q, target_d;
  logic            level_q, level_d;
  logic            bouncy_q, bouncy_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      cnt_q, cnt_d;

  logic            tick;
  logic            toggle_ok;
  logic            bounce_tick;

  assign tick        = (presc_q == TICK_LAST);
  assign bounce_tick = (state_q == BOUNCE) && en && tick;

`ifdef BOUNCE_RANDOM_EN
  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0] LFSR_INIT = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (bounce_tick) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign toggle_ok = lfsr_q[0];
`else
  logic unused_seed;
  logic unused_bounce_tick;
  assign unused_seed        = ^LFSR_SEED;
  assign unused_bounce_tick = bounce_tick;
  assign toggle_ok          = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    slot_d   = slot_q;
    target_d = target_q;
    level_d  = level_q;
    bouncy_d = bouncy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        presc_d  = '0;
        bouncy_d = level_q;
        if (en && (sw_clean != level_q)) begin
          target_d = sw_clean;
          slot_d   = SLOT_ONE;
          bouncy_d = sw_clean;
          state_d  = BOUNCE;
        end
      end

      BOUNCE: begin
        if (!en) begin
          // Abort: jump straight to the new level without a done pulse.
          state_d  = IDLE;
          presc_d  = '0;
          bouncy_d = target_q;
          level_d  = target_q;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (slot_q < BOUNCE_LAST) begin
              if (toggle_ok) begin
                bouncy_d = ~bouncy_q;
              end
              slot_d = slot_q + 1'b1;
            end else begin
              bouncy_d = target_q;
              slot_d   = SLOT_ONE;
              presc_d  = '0;
              state_d  = SETTLE;
            end
          end
        end
      end

      SETTLE: begin
        if (!en) begin
          state_d  = IDLE;
          presc_d  = '0;
          bouncy_d = target_q;
          level_d  = target_q;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (slot_q < STABLE_LAST) begin
              slot_d = slot_q + 1'b1;
            end else begin
              level_d = target_q;
              done_d  = 1'b1;
              presc_d = '0;
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        presc_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);

    // Every change of the registered output counts, saturating at 255.
    cnt_d = cnt_q;
    if ((bouncy_d != bouncy_q) && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      slot_q   <= '0;
      target_q <= 1'b0;
      level_q  <= 1'b0;
      bouncy_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      slot_q   <= slot_d;
      target_q <= target_d;
      level_q  <= level_d;
      bouncy_q <= bouncy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sw_bouncy  = bouncy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Directed bench for switch_bounce_gen: burst waveforms, back-to-back bursts, enable gating, abort and mid-burst reset.
module tb_switch_bounce_gen;

  localparam int TICK_DIV     = 4;
  localparam int BOUNCE_LEN   = 4;
  localparam int STABLE_TICKS = 2;
  localparam logic [7:0] SEED = 8'hA5;
  // Cycle index (relative to the sampling edge t) at which done is visible.
  localparam int DONE_K = 1 + TICK_DIV * (BOUNCE_LEN + STABLE_TICKS);

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       sw_clean;
  logic       sw_bouncy;
  logic       busy;
  logic       done;
  logic [7:0] toggle_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_lfsr;
  logic       m_b;
  logic       m_level;
  logic [7:0] m_cnt;

  always #5 clk = ~clk;

  switch_bounce_gen #(
    .TICK_DIV    (TICK_DIV),
    .BOUNCE_LEN  (BOUNCE_LEN),
    .STABLE_TICKS(STABLE_TICKS),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sw_clean  (sw_clean),
    .sw_bouncy (sw_bouncy),
    .busy      (busy),
    .done      (done),
    .toggle_cnt(toggle_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Expected sw_bouncy for cycle t+k of a burst toward tgt (abort forces tgt).
  task automatic model_step(input int k, input logic tgt, input logic abort);
    logic prev;
    prev = m_b;
    if (abort || k == 1) begin
      m_b = tgt;
    end else if (k > 1 && ((k - 1) % TICK_DIV) == 0 && (k - 1) / TICK_DIV < BOUNCE_LEN) begin
`ifdef BOUNCE_RANDOM_EN
      if (m_lfsr[0]) m_b = ~m_b;
      m_lfsr = lfsr_next(m_lfsr);
`else
      m_b = ~m_b;
`endif
    end else if (k == 1 + TICK_DIV * BOUNCE_LEN) begin
`ifdef BOUNCE_RANDOM_EN
      m_lfsr = lfsr_next(m_lfsr);
`endif
      m_b = tgt;
    end
    if (m_b != prev && m_cnt != 8'hFF) m_cnt++;
  endtask

  // Starts a burst toward tgt; optional pulse of sw_clean, en drop or reset after cycle t+k.
  task automatic run_burst(input logic tgt, input int pulse_k, input int drop_k, input int rst_k);
    logic was_reset;
    was_reset = 1'b0;
    sw_clean = tgt;
    for (int k = 1; k <= DONE_K; k++) begin
      @(negedge clk);
      if (rst_k != 0 && k == rst_k + 1) begin
        check("rst_bouncy", {31'd0, sw_bouncy}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cnt", {24'd0, toggle_cnt}, 32'd0);
        reset   = 1'b0;
        m_b     = 1'b0;
        m_cnt   = 8'd0;
        m_lfsr  = SEED;
        m_level = 1'b0;
        was_reset = 1'b1;
        break;
      end
      if (drop_k != 0 && k == drop_k + 1) begin
        model_step(k, tgt, 1'b1);
        check("abort_bouncy", {31'd0, sw_bouncy}, {31'd0, m_b});
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        en = 1'b1;
        break;
      end
      model_step(k, tgt, 1'b0);
      check($sformatf("bouncy_k%0d", k), {31'd0, sw_bouncy}, {31'd0, m_b});
      check($sformatf("busy_k%0d", k), {31'd0, busy}, {31'd0, (k < DONE_K)});
      check($sformatf("done_k%0d", k), {31'd0, done}, {31'd0, (k == DONE_K)});
      if (k == pulse_k) sw_clean = ~tgt;
      if (k == drop_k) en = 1'b0;
      if (k == rst_k) begin
        reset    = 1'b1;
        sw_clean = 1'b0;
      end
    end
    check("toggle_cnt", {24'd0, toggle_cnt}, {24'd0, m_cnt});
    if (!was_reset) m_level = tgt;
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b1;
    sw_clean = 1'b0;
    m_lfsr   = SEED;
    m_b      = 1'b0;
    m_level  = 1'b0;
    m_cnt    = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_bouncy", {31'd0, sw_bouncy}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_cnt", {24'd0, toggle_cnt}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Rising then falling burst.
    run_burst(1'b1, 0, 0, 0);
    run_burst(1'b0, 0, 0, 0);

    // Enable low: clean changes are ignored.
    en       = 1'b0;
    sw_clean = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("en_off_bouncy", {31'd0, sw_bouncy}, {31'd0, m_level});
      check("en_off_busy", {31'd0, busy}, 32'd0);
    end
    sw_clean = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);

    // Short pulse inside BOUNCE: burst to 1, one idle cycle, burst back to 0.
    run_burst(1'b1, 3, 0, 0);
    run_burst(1'b0, 0, 0, 0);

    // Enable dropped mid-burst.
    run_burst(1'b1, 0, 6, 0);
    @(negedge clk);
    check("post_abort_busy", {31'd0, busy}, 32'd0);
    check("post_abort_bouncy", {31'd0, sw_bouncy}, 32'd1);

    // Enough bursts to drive toggle_cnt into saturation.
    for (int i = 0; i < 50; i++) run_burst(~m_level, 0, 0, 0);

    // Reset in the middle of a burst.
    run_burst(~m_level, 0, 0, 10);
    repeat (3) @(negedge clk);
    check("after_rst_bouncy", {31'd0, sw_bouncy}, 32'd0);
    check("after_rst_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
